// File: rtl/uart_framer_pkg.sv
// Shared types and sizing helpers for the UART command/response framer.
package uart_framer_pkg;

  typedef enum logic {RX_IDLE, RX_COLLECT} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_LOAD, TX_WAIT} tx_state_t;

  // Byte counter width wide enough for either direction's byte count.
  function automatic int cnt_w(input int cmd_bytes, input int resp_bytes);
    int m;
    m = (cmd_bytes > resp_bytes) ? cmd_bytes : resp_bytes;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/uart_resp_serializer.sv
// Response serializer: shifts a RESP_BYTES-wide word out MSB-first, one UART
// byte per trmt pulse, advancing on each rising edge of tx_done.
module uart_resp_serializer import uart_framer_pkg::*; #(
  parameter int RESP_BYTES = 1,
  parameter int CNT_W      = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    send,
  input  logic [8*RESP_BYTES-1:0] resp,
  input  logic                    tx_done,
  output logic                    trmt,
  output logic [7:0]              tx_data,
  output logic                    resp_busy,
  output logic                    resp_done
);

  localparam int RW = 8 * RESP_BYTES;

  tx_state_t        r_state;
  logic [RW-1:0]    r_sh;
  logic [CNT_W-1:0] r_cnt;
  logic             r_txd_prev;
  logic             r_trmt;
  logic [7:0]       r_tx_data;
  logic             r_busy;
  logic             r_done;
  logic             w_txd_rise;

  assign w_txd_rise = tx_done & ~r_txd_prev;

  always_ff @(posedge clk) begin
    r_txd_prev <= tx_done;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= TX_IDLE;
      r_cnt     <= '0;
      r_trmt    <= 1'b0;
      r_tx_data <= 8'h00;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_trmt <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        // A send landing in the resp_done cycle is dropped on purpose.
        TX_IDLE: begin
          if (send && !r_done) begin
            r_sh    <= resp;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= TX_LOAD;
          end
        end
        TX_LOAD: begin
          r_trmt    <= 1'b1;
          r_tx_data <= r_sh[RW-1 -: 8];
          r_state   <= TX_WAIT;
        end
        TX_WAIT: begin
          if (w_txd_rise) begin
            if (r_cnt == CNT_W'(RESP_BYTES - 1)) begin
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= TX_IDLE;
            end else begin
              r_sh    <= r_sh << 8;
              r_cnt   <= r_cnt + 1'b1;
              r_state <= TX_LOAD;
            end
          end
        end
        default: r_state <= TX_IDLE;
      endcase
    end
  end

  assign trmt      = r_trmt;
  assign tx_data   = r_tx_data;
  assign resp_busy = r_busy;
  assign resp_done = r_done;

endmodule

// File: rtl/uart_cmd_framer.sv
// UART command/response framer: assembles CMD_BYTES bytes into cmd (MSB first)
// and serialises resp. Optional inter-byte timeout: `define UART_FRAMER_TIMEOUT_EN.
module uart_cmd_framer import uart_framer_pkg::*; #(
  parameter int CMD_BYTES   = 2,
  parameter int RESP_BYTES  = 1,
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rx_rdy,
  input  logic [7:0]              rx_data,
  output logic                    clr_rx_rdy,
  output logic [8*CMD_BYTES-1:0]  cmd,
  output logic                    cmd_rdy,
  input  logic                    clr_cmd_rdy,
  output logic                    ovr,
  output logic                    frm_err,
  input  logic                    send,
  input  logic [8*RESP_BYTES-1:0] resp,
  output logic                    trmt,
  output logic [7:0]              tx_data,
  input  logic                    tx_done,
  output logic                    resp_busy,
  output logic                    resp_done
);

  localparam int CW    = 8 * CMD_BYTES;
  localparam int CNT_W = cnt_w(CMD_BYTES, RESP_BYTES);

  rx_state_t        r_rx_state;
  logic [CNT_W-1:0] r_rx_cnt;
  logic [CW-1:0]    r_sh;
  logic [CW-1:0]    r_cmd;
  logic             r_cmd_rdy;
  logic             r_ovr;
  logic             w_last;
  logic             w_done;
  logic             w_timeout;
  logic [CW-1:0]    w_word;

  assign clr_rx_rdy = rx_rdy;
  assign w_last     = (r_rx_cnt == CNT_W'(CMD_BYTES - 1));
  assign w_done     = rx_rdy & w_last;
  // Older bytes fall off the top, so no clear is needed between commands.
  assign w_word     = (r_sh << 8) | CW'(rx_data);

  always_ff @(posedge clk) begin
    if (rx_rdy) r_sh <= w_word;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_state <= RX_IDLE;
      r_rx_cnt   <= '0;
      r_cmd      <= '0;
      r_cmd_rdy  <= 1'b0;
      r_ovr      <= 1'b0;
    end else begin
      if (rx_rdy) begin
        if (w_last) begin
          r_rx_cnt   <= '0;
          r_rx_state <= RX_IDLE;
          r_cmd      <= w_word;
        end else begin
          r_rx_cnt   <= r_rx_cnt + 1'b1;
          r_rx_state <= RX_COLLECT;
        end
      end else if (w_timeout) begin
        r_rx_cnt   <= '0;
        r_rx_state <= RX_IDLE;
      end
      // Completion wins over the consumer's acknowledge.
      if (w_done) begin
        r_cmd_rdy <= 1'b1;
        if (r_cmd_rdy && !clr_cmd_rdy) r_ovr <= 1'b1;
      end else if (clr_cmd_rdy) begin
        r_cmd_rdy <= 1'b0;
        r_ovr     <= 1'b0;
      end
    end
  end

  assign cmd     = r_cmd;
  assign cmd_rdy = r_cmd_rdy;
  assign ovr     = r_ovr;

`ifdef UART_FRAMER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [TW-1:0] r_to_cnt;
  logic          r_frm_err;

  // A byte arriving in the expiry cycle takes precedence over the timeout.
  assign w_timeout = (r_rx_state == RX_COLLECT) && !rx_rdy &&
                     (r_to_cnt == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_to_cnt  <= '0;
      r_frm_err <= 1'b0;
    end else begin
      r_frm_err <= w_timeout;
      if (rx_rdy || w_timeout || (r_rx_state != RX_COLLECT)) r_to_cnt <= '0;
      else                                                   r_to_cnt <= r_to_cnt + 1'b1;
    end
  end

  assign frm_err = r_frm_err;
`else
  logic w_unused_to;

  assign w_unused_to = (TIMEOUT_CYC == 0);
  assign w_timeout   = 1'b0;
  assign frm_err     = 1'b0;
`endif

  uart_resp_serializer #(
    .RESP_BYTES (RESP_BYTES),
    .CNT_W      (CNT_W)
  ) u_ser (
    .clk       (clk),
    .rst       (rst),
    .send      (send),
    .resp      (resp),
    .tx_done   (tx_done),
    .trmt      (trmt),
    .tx_data   (tx_data),
    .resp_busy (resp_busy),
    .resp_done (resp_done)
  );

endmodule
